// File: rtl/sram_req_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module : sram_req_arbiter_pkg
// Brief  : Shared tag encodings and default depth for the sram request arbiter.
// Rev    : 1.0
// ============================================================================
package sram_req_arbiter_pkg;

    typedef enum logic {
        TAG_INST = 1'b0,
        TAG_DATA = 1'b1
    } tag_e;

    localparam int unsigned c_DEPTH_DEFAULT = 4;

endpackage
`default_nettype wire

// File: rtl/sram_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module : sram_tag_fifo
// Brief  : In-order FIFO of 1-bit requester tags for outstanding transactions.
// Rev    : 1.0
// ============================================================================
module sram_tag_fifo
    import sram_req_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = c_DEPTH_DEFAULT
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       push,
    input  tag_e                       push_tag,
    input  logic                       pop,
    output logic                       full,
    output logic                       empty,
    output tag_e                       head,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned c_PTR_W = $clog2(DEPTH);
    localparam int unsigned c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(DEPTH);

    tag_e               r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_push;
    logic               w_pop;

    assign full   = (r_count == c_FULL_CNT);
    assign empty  = (r_count == '0);
    assign head   = r_mem[r_rd_ptr];
    assign count  = r_count;
    // Full/empty come from the registered count, so a same-cycle pop never frees a slot early.
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int k = 0; k < int'(DEPTH); k++) begin
                r_mem[k] <= TAG_INST;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= push_tag;
                r_wr_ptr        <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/sram_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module : sram_req_arbiter
// Brief  : Merges instruction and data sram-like requesters onto one master.
// Rev    : 1.0
// ============================================================================
module sram_req_arbiter
    import sram_req_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = c_DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_req,
    input  logic        i_wr,
    input  logic [1:0]  i_size,
    input  logic [3:0]  i_wstrb,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        i_addr_ok,
    output logic        i_data_ok,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [1:0]  d_size,
    input  logic [3:0]  d_wstrb,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_addr_ok,
    output logic        d_data_ok,
    output logic [31:0] d_rdata,
    output logic        m_req,
    output logic        m_wr,
    output logic [1:0]  m_size,
    output logic [3:0]  m_wstrb,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    input  logic [31:0] m_rdata,
    output logic        busy,
    output logic        err
);

    logic                   r_lock;
    tag_e                   r_lock_grant;
    logic                   r_err;
    tag_e                   w_grant;
    logic                   w_sel_data;
    logic                   w_full;
    logic                   w_empty;
    tag_e                   w_head;
    logic                   w_push;
    logic                   w_pop;
    logic [$clog2(DEPTH):0] w_count;

    // A stalled master request keeps its grant so its fields stay stable.
    always_comb begin
        w_grant = TAG_INST;
        if (r_lock) begin
            w_grant = r_lock_grant;
        end else if (d_req) begin
            w_grant = TAG_DATA;
        end
    end

    assign w_sel_data = (w_grant == TAG_DATA);

    assign m_req   = resetn & ~w_full & (w_sel_data ? d_req : i_req);
    assign m_wr    = w_sel_data ? d_wr    : i_wr;
    assign m_size  = w_sel_data ? d_size  : i_size;
    assign m_wstrb = w_sel_data ? d_wstrb : i_wstrb;
    assign m_addr  = w_sel_data ? d_addr  : i_addr;
    assign m_wdata = w_sel_data ? d_wdata : i_wdata;

    assign i_addr_ok = m_addr_ok & m_req & ~w_sel_data;
    assign d_addr_ok = m_addr_ok & m_req &  w_sel_data;

    assign w_push = m_req & m_addr_ok;
    assign w_pop  = m_data_ok & ~w_empty;

    assign i_data_ok = w_pop & (w_head == TAG_INST);
    assign d_data_ok = w_pop & (w_head == TAG_DATA);
    assign i_rdata   = m_rdata;
    assign d_rdata   = m_rdata;

    assign busy = (w_count != '0);
    assign err  = r_err;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_lock       <= 1'b0;
            r_lock_grant <= TAG_INST;
            r_err        <= 1'b0;
        end else begin
            r_lock       <= m_req & ~m_addr_ok;
            r_lock_grant <= w_grant;
            r_err        <= r_err | (m_data_ok & w_empty);
        end
    end

    sram_tag_fifo #(
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk      (clk),
        .resetn   (resetn),
        .push     (w_push),
        .push_tag (w_grant),
        .pop      (w_pop),
        .full     (w_full),
        .empty    (w_empty),
        .head     (w_head),
        .count    (w_count)
    );

endmodule
`default_nettype wire
